// File: rtl/flag_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : flag_pkg                                                  |
// | Brief    : NZCV flag type, flag bit indices and a packing helper     |
// | Revision : 1.0  initial parametrised pipelined flag unit             |
// +----------------------------------------------------------------------+
package flag_pkg;

    // Architectural condition flags, MSB first: {N,Z,C,V}.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Assemble a flags_t from its four components.
    function automatic flags_t pack_flags(input logic n, input logic z,
                                          input logic c, input logic v);
        flags_t f;
        f.n = n;
        f.z = z;
        f.c = c;
        f.v = v;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flag_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : flag_unit_if                                              |
// | Brief    : ALU-result / flag bus between execute stage and flag unit |
// | Revision : 1.0  initial parametrised pipelined flag unit             |
// +----------------------------------------------------------------------+
interface flag_unit_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    import flag_pkg::*;

    logic             in_valid;
    logic [WIDTH-1:0] result;
    logic             carry_in;
    logic             overflow_in;
    logic             set_flags;
    logic             flush;
    logic             cnt_clr;

    logic             out_valid;
    logic             zero;
    flags_t           flags_new;
    flags_t           flags_q;
    flags_t           flags_fwd;
    logic [CNT_W-1:0] zero_cnt;

    // Execute stage side: drives results, observes flags.
    modport master (
        output in_valid, result, carry_in, overflow_in, set_flags, flush, cnt_clr,
        input  out_valid, zero, flags_new, flags_q, flags_fwd, zero_cnt
    );

    // Flag unit side.
    modport slave (
        input  in_valid, result, carry_in, overflow_in, set_flags, flush, cnt_clr,
        output out_valid, zero, flags_new, flags_q, flags_fwd, zero_cnt
    );

endinterface
`default_nettype wire

// File: rtl/flag_unit_nor_reduce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : nor_reduce                                                |
// | Brief    : W-input NOR built from a chain of gate primitives         |
// | Revision : 1.0  initial parametrised pipelined flag unit             |
// +----------------------------------------------------------------------+
module nor_reduce #(
    parameter int W = 16
)(
    input  wire [W-1:0] a,
    output wire         y
);

    // w_or_chain[k] is the OR of a[k:0]; the last tap is inverted.
    wire [W-1:0] w_or_chain;

    buf u_buf0 (w_or_chain[0], a[0]);

    genvar gi;
    generate
        for (gi = 1; gi < W; gi++) begin : g_or_chain
            or u_or (w_or_chain[gi], w_or_chain[gi-1], a[gi]);
        end
    endgenerate

    not u_not (y, w_or_chain[W-1]);

endmodule
`default_nettype wire

// File: rtl/flag_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : flag_unit                                                 |
// | Brief    : Zero detect via grouped NORs, NZCV register with          |
// |            set-flags/flush, flag forwarding and zero-result counter  |
// | Revision : 1.0  initial parametrised pipelined flag unit             |
// +----------------------------------------------------------------------+
module flag_unit
    import flag_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int GROUP = 16,
    parameter int PIPE  = 1,
    parameter int CNT_W = 16
)(
    input wire logic    clk,
    input wire logic    reset_n,
    flag_unit_if.slave  bus
);

    localparam int NGRP = WIDTH / GROUP;

    generate
        if (((WIDTH % GROUP) != 0) || (PIPE < 0) || (PIPE > 1)) begin : g_param_check
            $error("flag_unit: WIDTH must be a multiple of GROUP and PIPE must be 0 or 1");
        end
    endgenerate

    // ---------------- Stage A: group NORs ----------------
    logic [NGRP-1:0] w_grp_nor;
    logic            w_a_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_groups
            nor_reduce #(.W(GROUP)) u_nor (
                .a (bus.result[gi*GROUP +: GROUP]),
                .y (w_grp_nor[gi])
            );
        end
    endgenerate

    // A flushed input never enters the pipe.
    assign w_a_valid = bus.in_valid & ~bus.flush;

    // ---------------- Stage B ----------------
    logic            w_b_valid;
    logic [NGRP-1:0] w_b_grp;
    logic            w_b_n;
    logic            w_b_c;
    logic            w_b_v;
    logic            w_b_set;

    generate
        if (PIPE == 1) begin : g_pipe
            logic            r_valid;
            logic [NGRP-1:0] r_grp;
            logic            r_n;
            logic            r_c;
            logic            r_v;
            logic            r_set;

            // Register stage A; data only loads on a live entry, valid always tracks.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_valid <= 1'b0;
                    r_grp   <= '0;
                    r_n     <= 1'b0;
                    r_c     <= 1'b0;
                    r_v     <= 1'b0;
                    r_set   <= 1'b0;
                end else begin
                    r_valid <= w_a_valid;
                    if (w_a_valid) begin
                        r_grp <= w_grp_nor;
                        r_n   <= bus.result[WIDTH-1];
                        r_c   <= bus.carry_in;
                        r_v   <= bus.overflow_in;
                        r_set <= bus.set_flags;
                    end
                end
            end

            // Flush kills the entry currently sitting in stage B.
            assign w_b_valid = r_valid & ~bus.flush;
            assign w_b_grp   = r_grp;
            assign w_b_n     = r_n;
            assign w_b_c     = r_c;
            assign w_b_v     = r_v;
            assign w_b_set   = r_set;
        end else begin : g_comb
            assign w_b_valid = w_a_valid;
            assign w_b_grp   = w_grp_nor;
            assign w_b_n     = bus.result[WIDTH-1];
            assign w_b_c     = bus.carry_in;
            assign w_b_v     = bus.overflow_in;
            assign w_b_set   = bus.set_flags;
        end
    endgenerate

    logic   w_b_z;
    flags_t w_flags_new;
    logic   w_wr;
    flags_t r_flags_q;
    logic [CNT_W-1:0] r_cnt;

    assign w_b_z       = &w_b_grp;
    assign w_flags_new = w_b_valid ? pack_flags(w_b_n, w_b_z, w_b_c, w_b_v) : '0;
    // w_b_valid already excludes flushed entries in both pipe modes.
    assign w_wr        = w_b_valid & w_b_set;

    // Architectural NZCV register: written by a retiring set-flags entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags_q <= '0;
        end else if (w_wr) begin
            r_flags_q <= w_flags_new;
        end
    end

    // Saturating zero-result counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_cnt <= '0;
        end else if (w_b_valid && w_b_z && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid = w_b_valid;
    assign bus.zero      = w_b_valid & w_b_z;
    assign bus.flags_new = w_flags_new;
    assign bus.flags_q   = r_flags_q;
    assign bus.flags_fwd = w_wr ? w_flags_new : r_flags_q;
    assign bus.zero_cnt  = r_cnt;

endmodule
`default_nettype wire
